// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async FIFO write port between NumReq
// valid/ready requesters; a grant lasts up to MaxBurst accepted beats.
module fifo_wr_arbiter #(
    parameter  int NumReq    = 4,
    parameter  int DataWidth = 4,
    parameter  int MaxBurst  = 4,
    localparam int IdWidth   = $clog2(NumReq)
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NumReq-1:0]           req_valid,
    input  logic [NumReq*DataWidth-1:0] req_data,
    output logic [NumReq-1:0]           req_ready,
    output logic                        wvalid,
    output logic [DataWidth-1:0]        wdata,
    input  logic                        wready,
    output logic [IdWidth-1:0]          grant_id,
    output logic                        busy
);

    localparam int CntWidth = $clog2(MaxBurst + 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t                state_r, state_s;
    logic [IdWidth-1:0]    owner_r, owner_s;
    logic [IdWidth-1:0]    rr_ptr_r, rr_ptr_s;
    logic [CntWidth-1:0]   beat_cnt_r, beat_cnt_s;
    logic                  busy_s;
    logic                  owner_valid_s;
    logic                  wvalid_s;
    logic                  accept_s;
    logic                  release_s;
    logic [IdWidth-1:0]    next_ptr_s;
    logic [IdWidth-1:0]    pick_base_s;
    logic [IdWidth-1:0]    pick_s;

    // First valid requester at or after base, wrapping modulo NumReq.
    function automatic logic [IdWidth-1:0] rr_pick(
        input logic [NumReq-1:0]  valid,
        input logic [IdWidth-1:0] base
    );
        logic found;
        int   idx;
        rr_pick = base;
        found   = 1'b0;
        for (int k = 0; k < NumReq; k++) begin
            idx = (int'(base) + k) % NumReq;
            if (!found && valid[idx]) begin
                rr_pick = IdWidth'(idx);
                found   = 1'b1;
            end
        end
    endfunction

    // Write-port muxing from the current owner; wready never feeds wvalid.
    always_comb begin
        busy_s        = (state_r == ST_GRANT);
        owner_valid_s = req_valid[owner_r];
        wvalid_s      = busy_s && owner_valid_s;
        accept_s      = wvalid_s && wready;
        wdata         = {DataWidth{1'b0}};
        req_ready     = {NumReq{1'b0}};
        for (int i = 0; i < NumReq; i++) begin
            if (busy_s && (owner_r == IdWidth'(i))) begin
                req_ready[i] = wready;
                if (wvalid_s) begin
                    wdata = req_data[i*DataWidth +: DataWidth];
                end else begin
                    wdata = {DataWidth{1'b0}};
                end
            end else begin
                req_ready[i] = 1'b0;
            end
        end
        wvalid   = wvalid_s;
        busy     = busy_s;
        grant_id = owner_r;
    end

    // Release condition and the pointer the next arbitration scans from.
    always_comb begin
        release_s = (accept_s && (beat_cnt_r == CntWidth'(MaxBurst - 1))) || !owner_valid_s;
        if (owner_r == IdWidth'(NumReq - 1)) begin
            next_ptr_s = {IdWidth{1'b0}};
        end else begin
            next_ptr_s = owner_r + {{(IdWidth-1){1'b0}}, 1'b1};
        end
        if (state_r == ST_GRANT) begin
            pick_base_s = next_ptr_s;
        end else begin
            pick_base_s = rr_ptr_r;
        end
        pick_s = rr_pick(req_valid, pick_base_s);
    end

    // Next-state: grant on request, rotate on burst end or owner drop.
    always_comb begin
        state_s    = state_r;
        owner_s    = owner_r;
        rr_ptr_s   = rr_ptr_r;
        beat_cnt_s = beat_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (|req_valid) begin
                    owner_s    = pick_s;
                    beat_cnt_s = {CntWidth{1'b0}};
                    state_s    = ST_GRANT;
                end else begin
                    state_s    = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (release_s) begin
                    rr_ptr_s = next_ptr_s;
                    if (|req_valid) begin
                        owner_s    = pick_s;
                        beat_cnt_s = {CntWidth{1'b0}};
                        state_s    = ST_GRANT;
                    end else begin
                        beat_cnt_s = {CntWidth{1'b0}};
                        state_s    = ST_IDLE;
                    end
                end else if (accept_s) begin
                    beat_cnt_s = beat_cnt_r + {{(CntWidth-1){1'b0}}, 1'b1};
                end else begin
                    beat_cnt_s = beat_cnt_r;
                end
            end
            default: begin
                state_s    = ST_IDLE;
                owner_s    = {IdWidth{1'b0}};
                rr_ptr_s   = {IdWidth{1'b0}};
                beat_cnt_s = {CntWidth{1'b0}};
            end
        endcase
    end

    // State register with asynchronous abort of any grant in progress.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            owner_r    <= {IdWidth{1'b0}};
            rr_ptr_r   <= {IdWidth{1'b0}};
            beat_cnt_r <= {CntWidth{1'b0}};
        end else begin
            state_r    <= state_s;
            owner_r    <= owner_s;
            rr_ptr_r   <= rr_ptr_s;
            beat_cnt_r <= beat_cnt_s;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus randomized traffic
// compared against a behavioural round-robin model.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 4;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [N-1:0]  req_valid = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]  req_ready;
    logic          wvalid;
    logic [DW-1:0] wdata;
    logic          wready = 1'b0;
    logic [1:0]    grant_id;
    logic          busy;

    int checks = 0;
    int errors = 0;

    // model state
    int m_busy, m_owner, m_beats, m_ptr, m_acc_src;

    fifo_wr_arbiter #(.NumReq(N), .DataWidth(DW), .MaxBurst(MB)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .wvalid(wvalid), .wdata(wdata), .wready(wready),
        .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic int scan_first(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return ptr;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_beats = 0; m_ptr = 0; m_acc_src = -1;
    endtask

    // Apply the arbitration rules for one clock edge with the current inputs.
    task automatic model_edge();
        bit acc;
        m_acc_src = -1;
        if (m_busy == 0) begin
            if (req_valid != 0) begin
                m_owner = scan_first(req_valid, m_ptr);
                m_beats = 0;
                m_busy  = 1;
            end
        end else begin
            acc = req_valid[m_owner] && wready;
            if (acc) begin
                m_beats++;
                m_acc_src = m_owner;
            end
            if ((acc && m_beats == MB) || !req_valid[m_owner]) begin
                m_ptr = (m_owner + 1) % N;
                if (req_valid != 0) begin
                    m_owner = scan_first(req_valid, m_ptr);
                    m_beats = 0;
                end else begin
                    m_busy = 0;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; req_valid = '0; req_data = '0; wready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #1;
        checks++;
        if ({busy, wvalid, req_ready, grant_id, wdata} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %0h expected 0", {busy, wvalid, req_ready, grant_id, wdata});
        end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        req_valid = 4'b0100; wready = 1'b1; req_data[2*DW +: DW] = 4'd0;
        @(negedge clk);
        checks++;
        if (wvalid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_latency: got wvalid=%b busy=%b expected 0 0", wvalid, busy);
        end
        tick();
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b1 || grant_id !== 2'd2 || wvalid !== 1'b1 || wdata !== 4'(k)) begin
                errors++;
                $display("FAIL single_stream[%0d]: got busy=%b id=%0d wv=%b wd=%0h expected 1 2 1 %0h",
                         k, busy, grant_id, wvalid, wdata, k[3:0]);
            end
            tick();
            req_data[2*DW +: DW] = 4'(k + 1);
        end
        req_valid = '0;
    endtask

    task automatic test_all_valid();
        int order[$];
        do_reset();
        req_valid = 4'hF; wready = 1'b1; req_data = 16'h3210;
        for (int c = 0; c < 40 && order.size() < 17; c++) begin
            @(negedge clk);
            checks++;
            if ($countones(req_ready) > 1) begin
                errors++;
                $display("FAIL ready_onehot: got %b expected one-hot or 0", req_ready);
            end
            if (wvalid && wready) order.push_back(int'(grant_id));
            tick();
        end
        checks++;
        if (order.size() != 17) begin
            errors++;
            $display("FAIL rr_order_len: got %0d expected 17", order.size());
        end
        for (int k = 0; k < order.size(); k++) begin
            checks++;
            if (order[k] != (k / MB) % N) begin
                errors++;
                $display("FAIL rr_order[%0d]: got %0d expected %0d", k, order[k], (k / MB) % N);
            end
        end
        req_valid = '0;
    endtask

    task automatic test_stall();
        do_reset();
        req_valid = 4'hF; wready = 1'b1;
        tick();
        tick(); tick();
        wready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (grant_id !== 2'd0 || wvalid !== 1'b1 || req_ready !== 4'b0000) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got id=%0d wv=%b rdy=%b expected 0 1 0000",
                         k, grant_id, wvalid, req_ready);
            end
            tick();
        end
        wready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if (grant_id !== 2'd0 || req_ready !== 4'b0001) begin
                errors++;
                $display("FAIL stall_resume[%0d]: got id=%0d rdy=%b expected 0 0001", k, grant_id, req_ready);
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (grant_id !== 2'd1) begin
            errors++;
            $display("FAIL stall_rotate: got %0d expected 1", grant_id);
        end
        req_valid = '0;
    endtask

    task automatic test_early_release();
        do_reset();
        req_valid = 4'b1010; wready = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if (grant_id !== 2'd1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL early_first: got id=%0d busy=%b expected 1 1", grant_id, busy);
        end
        tick(); tick();
        req_valid = 4'b1000;
        @(negedge clk);
        checks++;
        if (wvalid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL early_drop: got wv=%b busy=%b expected 0 1", wvalid, busy);
        end
        tick();
        @(negedge clk);
        checks++;
        if (grant_id !== 2'd3 || busy !== 1'b1 || wvalid !== 1'b1) begin
            errors++;
            $display("FAIL early_next: got id=%0d busy=%b wv=%b expected 3 1 1", grant_id, busy, wvalid);
        end
        req_valid = '0;
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        req_valid = 4'hF; wready = 1'b1;
        repeat (7) tick();
        checks++;
        if (grant_id !== 2'd1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre: got id=%0d busy=%b expected 1 1", grant_id, busy);
        end
        #3 reset_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || wvalid !== 1'b0 || req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL midrst_abort: got busy=%b wv=%b rdy=%b expected 0 0 0000", busy, wvalid, req_ready);
        end
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if (grant_id !== 2'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL midrst_regrant: got id=%0d busy=%b expected 0 1", grant_id, busy);
        end
        req_valid = '0;
    endtask

    task automatic test_random_traffic();
        int seq[N];
        int exp_seq[N];
        logic e_wv;
        logic [DW-1:0] e_wd;
        logic [N-1:0] e_rdy;
        do_reset();
        for (int i = 0; i < N; i++) begin
            seq[i] = 0; exp_seq[i] = 0;
        end
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            e_wv  = (m_busy != 0) && req_valid[m_owner];
            e_wd  = e_wv ? req_data[m_owner*DW +: DW] : '0;
            e_rdy = ((m_busy != 0) && wready) ? (4'b0001 << m_owner) : 4'b0000;
            checks++;
            if (busy !== (m_busy != 0) || wvalid !== e_wv || wdata !== e_wd || req_ready !== e_rdy ||
                ((m_busy != 0) && grant_id !== 2'(m_owner))) begin
                errors++;
                $display("FAIL random[%0d]: got busy=%b id=%0d wv=%b wd=%0h rdy=%b expected %0d %0d %b %0h %b",
                         c, busy, grant_id, wvalid, wdata, req_ready, m_busy, m_owner, e_wv, e_wd, e_rdy);
            end
            if (wvalid && wready) begin
                checks++;
                if (wdata !== 4'(exp_seq[grant_id])) begin
                    errors++;
                    $display("FAIL integrity src%0d: got %0h expected %0h", grant_id, wdata, exp_seq[grant_id] % 16);
                end
                exp_seq[grant_id]++;
            end
            tick();
            for (int i = 0; i < N; i++) begin
                if (m_acc_src == i) begin
                    seq[i]++;
                    req_data[i*DW +: DW] = 4'(seq[i]);
                    if ($urandom_range(0, 9) < 3) req_valid[i] = 1'b0;
                end else if (!req_valid[i] && $urandom_range(0, 9) < 4) begin
                    req_valid[i] = 1'b1;
                end
            end
            wready = ($urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (exp_seq[i] != seq[i]) begin
                errors++;
                $display("FAIL beat_count src%0d: got %0d expected %0d", i, exp_seq[i], seq[i]);
            end
        end
        req_valid = '0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_all_valid();
        test_stall();
        test_early_release();
        test_reset_mid_burst();
        test_random_traffic();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
